// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART TX frame arbiter: frame layout, FSM encoding,
// and a frame packing helper.
package uart_arb_pkg;

    localparam int FRAME_W_DEF = 21;

    // Frame layout: {mode, addr[11:0], data[7:0]}
    localparam int DATA_LSB = 0;
    localparam int DATA_W   = 8;
    localparam int ADDR_LSB = 8;
    localparam int ADDR_W   = 12;
    localparam int MODE_LSB = 20;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } arb_state_t;

    function automatic logic [FRAME_W_DEF-1:0] pack_frame(
        input logic              mode,
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] data
    );
        logic [FRAME_W_DEF-1:0] f;
        f                       = '0;
        f[MODE_LSB]             = mode;
        f[ADDR_LSB +: ADDR_W]   = addr;
        f[DATA_LSB +: DATA_W]   = data;
        return f;
    endfunction

endpackage

// File: rtl/uart_arb_rr_pick.sv
// Combinational grant selector. Round-robin from last_grant+1 by default;
// lowest-index fixed priority when ARB_FIXED_PRIO_EN is defined.
module uart_arb_rr_pick
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_valid,
    input  logic [IDX_W-1:0]   i_last_grant,
    output logic [IDX_W-1:0]   o_grant,
    output logic               o_any_valid
);

    logic w_found;
    int   w_idx;

    assign o_any_valid = |i_valid;

`ifdef ARB_FIXED_PRIO_EN
    logic w_unused_last;
    assign w_unused_last = ^i_last_grant;

    // Lowest-indexed valid requester wins.
    always_comb begin
        w_found = 1'b0;
        w_idx   = 0;
        o_grant = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_found && i_valid[k]) begin
                w_found = 1'b1;
                w_idx   = k;
                o_grant = IDX_W'(k);
            end else begin
                w_found = w_found;
            end
        end
    end
`else
    // Search upward from the requester after last_grant, wrapping modulo NUM_REQ.
    always_comb begin
        w_found = 1'b0;
        w_idx   = 0;
        o_grant = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = (int'(i_last_grant) + k) % NUM_REQ;
            if (!w_found && i_valid[w_idx[IDX_W-1:0]]) begin
                w_found = 1'b1;
                o_grant = w_idx[IDX_W-1:0];
            end else begin
                w_found = w_found;
            end
        end
    end
`endif

endmodule

// File: rtl/uart_tx_frame_arbiter.sv
// Arbitrates NUM_REQ frame requesters onto one UART TX adapter port.
// Selection policy is chosen by ARB_FIXED_PRIO_EN (see uart_arb_rr_pick).
module uart_tx_frame_arbiter
    import uart_arb_pkg::*;
#(
    parameter int          NUM_REQ     = 4,
    parameter int          FRAME_W     = FRAME_W_DEF,
    parameter logic [15:0] CNT_RST_VAL = 16'h0000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ*FRAME_W-1:0] req_frame,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [FRAME_W-1:0]         out_frame,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(NUM_REQ)-1:0] out_src,
    output logic [15:0]                frame_count
);

    localparam int IDX_W = $clog2(NUM_REQ);

    arb_state_t         r_state;
    arb_state_t         w_state_nxt;
    logic [FRAME_W-1:0] r_out_frame;
    logic [IDX_W-1:0]   r_out_src;
    logic [IDX_W-1:0]   r_last_grant;
    logic [15:0]        r_frame_count;

    logic [IDX_W-1:0]   w_grant;
    logic               w_any_valid;
    logic               w_accept;
    logic               w_deliver;
    logic [NUM_REQ-1:0] w_req_ready;
    logic [FRAME_W-1:0] w_sel_frame;

    uart_arb_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .i_valid      (req_valid),
        .i_last_grant (r_last_grant),
        .o_grant      (w_grant),
        .o_any_valid  (w_any_valid)
    );

    // Next-state logic; accept and deliver are the two handshake events.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_deliver   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_OFFER;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_OFFER: begin
                if (out_ready) begin
                    w_deliver   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_OFFER;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Accept strobe is combinational so it lands in the same cycle the
    // requester's valid is seen; masked while reset is held.
    always_comb begin
        w_req_ready = '0;
        if (w_accept && !rst) begin
            w_req_ready = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_grant;
        end else begin
            w_req_ready = '0;
        end
    end

    // Granted requester's frame slice.
    always_comb begin
        w_sel_frame = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (w_grant == IDX_W'(k)) begin
                w_sel_frame = req_frame[k*FRAME_W +: FRAME_W];
            end else begin
                w_sel_frame = w_sel_frame;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Held frame, owner, round-robin pointer and delivered-frame counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_frame   <= '0;
            r_out_src     <= '0;
            r_last_grant  <= IDX_W'(NUM_REQ - 1);
            r_frame_count <= CNT_RST_VAL;
        end else begin
            if (w_accept) begin
                r_out_frame <= w_sel_frame;
                r_out_src   <= w_grant;
            end
            if (w_deliver) begin
                r_last_grant <= r_out_src;
                if (r_frame_count != 16'hFFFF) begin
                    r_frame_count <= r_frame_count + 16'd1;
                end
            end
        end
    end

    assign req_ready   = w_req_ready;
    assign out_frame   = r_out_frame;
    assign out_valid   = (r_state == ST_OFFER);
    assign out_src     = r_out_src;
    assign frame_count = r_frame_count;

endmodule

// File: tb/tb_uart_tx_frame_arbiter.sv
// Directed self-checking bench for uart_tx_frame_arbiter (both selection builds).
module tb_uart_tx_frame_arbiter;
    import uart_arb_pkg::*;

    localparam int NR = 4;
    localparam int FW = 21;

    logic              clk;
    logic              rst;
    logic [NR*FW-1:0]  req_frame;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [FW-1:0]     out_frame;
    logic              out_valid;
    logic              out_ready;
    logic [1:0]        out_src;
    logic [15:0]       frame_count;

    logic [NR*FW-1:0]  s_req_frame;
    logic [NR-1:0]     s_req_valid;
    logic [NR-1:0]     s_req_ready;
    logic [FW-1:0]     s_out_frame;
    logic              s_out_valid;
    logic              s_out_ready;
    logic [1:0]        s_out_src;
    logic [15:0]       s_frame_count;

    logic [FW-1:0]     frm [NR];
    int                n_vec;
    int                n_bad;

    uart_tx_frame_arbiter #(.NUM_REQ(NR), .FRAME_W(FW)) dut (
        .clk (clk), .rst (rst), .req_frame (req_frame), .req_valid (req_valid),
        .req_ready (req_ready), .out_frame (out_frame), .out_valid (out_valid),
        .out_ready (out_ready), .out_src (out_src), .frame_count (frame_count)
    );

    uart_tx_frame_arbiter #(.NUM_REQ(NR), .FRAME_W(FW), .CNT_RST_VAL(16'hFFFD)) dut_sat (
        .clk (clk), .rst (rst), .req_frame (s_req_frame), .req_valid (s_req_valid),
        .req_ready (s_req_ready), .out_frame (s_out_frame), .out_valid (s_out_valid),
        .out_ready (s_out_ready), .out_src (s_out_src), .frame_count (s_frame_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        req_valid = 4'b0000;
        out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        req_valid = 4'b1111;
        out_ready = 1'b1;
        req_frame = {frm[3], frm[2], frm[1], frm[0]};
        @(negedge clk); #1;
        n_vec++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        n_vec++; if (out_frame !== 21'h0) begin n_bad++; $display("FAIL reset_out_frame got=%h exp=0", out_frame); end
        n_vec++; if (out_src !== 2'd0) begin n_bad++; $display("FAIL reset_out_src got=%0d exp=0", out_src); end
        n_vec++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL reset_req_ready got=%b exp=0000", req_ready); end
        n_vec++; if (frame_count !== 16'h0000) begin n_bad++; $display("FAIL reset_frame_count got=%h exp=0000", frame_count); end
    endtask

    task automatic test_single();
        @(negedge clk);
        rst              = 1'b0;
        req_frame        = '0;
        req_frame[20:0]  = 21'h1ABC5A;
        req_valid        = 4'b0001;
        out_ready        = 1'b1;
        #1;
        n_vec++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL single_ready got=%b exp=0001", req_ready); end
        n_vec++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL single_pre_valid got=%b exp=0", out_valid); end
        @(negedge clk);
        req_valid = 4'b0000;
        #1;
        n_vec++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL single_valid got=%b exp=1", out_valid); end
        n_vec++; if (out_frame !== 21'h1ABC5A) begin n_bad++; $display("FAIL single_frame got=%h exp=1abc5a", out_frame); end
        n_vec++; if (out_src !== 2'd0) begin n_bad++; $display("FAIL single_src got=%0d exp=0", out_src); end
        n_vec++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL single_ready_offer got=%b exp=0000", req_ready); end
        @(negedge clk); #1;
        n_vec++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL single_drop got=%b exp=0", out_valid); end
        n_vec++; if (frame_count !== 16'd1) begin n_bad++; $display("FAIL single_count got=%0d exp=1", frame_count); end
    endtask

    task automatic test_round_robin();
        logic [3:0] one;
        int         exp;
        do_reset();
        req_frame = {frm[3], frm[2], frm[1], frm[0]};
        req_valid = 4'b1111;
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
`ifdef ARB_FIXED_PRIO_EN
            exp = 0;
`else
            exp = k % NR;
`endif
            one = 4'b0001 << exp;
            #1;
            n_vec++; if (req_ready !== one) begin n_bad++; $display("FAIL rr_ready[%0d] got=%b exp=%b", k, req_ready, one); end
            n_vec++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rr_idle_valid[%0d] got=%b exp=0", k, out_valid); end
            @(negedge clk); #1;
            n_vec++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL rr_valid[%0d] got=%b exp=1", k, out_valid); end
            n_vec++; if (out_src !== 2'(exp)) begin n_bad++; $display("FAIL rr_src[%0d] got=%0d exp=%0d", k, out_src, exp); end
            n_vec++; if (out_frame !== frm[exp]) begin n_bad++; $display("FAIL rr_frame[%0d] got=%h exp=%h", k, out_frame, frm[exp]); end
            @(negedge clk);
        end
        #1;
        n_vec++; if (frame_count !== 16'd6) begin n_bad++; $display("FAIL rr_count got=%0d exp=6", frame_count); end
        req_valid = 4'b0000;
    endtask

    task automatic test_backpressure();
        int         g1;
        int         g2;
        logic [3:0] one;
`ifdef ARB_FIXED_PRIO_EN
        g1 = 0; g2 = 0;
`else
        g1 = 3; g2 = 0;
`endif
        req_valid = 4'b1001;
        out_ready = 1'b0;
        one = 4'b0001 << g1;
        #1;
        n_vec++; if (req_ready !== one) begin n_bad++; $display("FAIL bp_ready got=%b exp=%b", req_ready, one); end
        @(negedge clk);
        for (int c = 0; c < 50; c++) begin
            #1;
            n_vec++;
            if (out_valid !== 1'b1 || out_src !== 2'(g1) || out_frame !== frm[g1] || req_ready !== 4'b0000) begin
                n_bad++;
                $display("FAIL bp_hold[%0d] got v=%b src=%0d frame=%h rdy=%b exp v=1 src=%0d frame=%h rdy=0000",
                         c, out_valid, out_src, out_frame, req_ready, g1, frm[g1]);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        n_vec++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_before_edge got=%b exp=1", out_valid); end
        @(negedge clk); #1;
        one = 4'b0001 << g2;
        n_vec++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_done got=%b exp=0", out_valid); end
        n_vec++; if (frame_count !== 16'd7) begin n_bad++; $display("FAIL bp_count got=%0d exp=7", frame_count); end
        n_vec++; if (req_ready !== one) begin n_bad++; $display("FAIL bp_next_ready got=%b exp=%b", req_ready, one); end
        @(negedge clk);
        req_valid = 4'b0000;
        @(negedge clk); #1;
        n_vec++; if (frame_count !== 16'd8) begin n_bad++; $display("FAIL bp_count2 got=%0d exp=8", frame_count); end
    endtask

    task automatic test_idle_ready();
        req_valid = 4'b0000;
        out_ready = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        n_vec++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL idle_valid got=%b exp=0", out_valid); end
        n_vec++; if (frame_count !== 16'd8) begin n_bad++; $display("FAIL idle_count got=%0d exp=8", frame_count); end
        n_vec++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL idle_ready got=%b exp=0000", req_ready); end
    endtask

    task automatic test_reset_mid_offer();
        do_reset();
        req_valid = 4'b0010;
        out_ready = 1'b0;
        @(negedge clk);
        req_valid = 4'b0000;
        #1;
        n_vec++; if (out_valid !== 1'b1 || out_src !== 2'd1) begin n_bad++; $display("FAIL mid_offer got v=%b src=%0d exp v=1 src=1", out_valid, out_src); end
        rst = 1'b1;
        #1;
        n_vec++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_async_drop got=%b exp=0", out_valid); end
        n_vec++; if (frame_count !== 16'd0) begin n_bad++; $display("FAIL mid_count got=%0d exp=0", frame_count); end
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        n_vec++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_no_reoffer got=%b exp=0", out_valid); end
        n_vec++; if (frame_count !== 16'd0) begin n_bad++; $display("FAIL mid_count_after got=%0d exp=0", frame_count); end
    endtask

    task automatic test_two_req();
        int exp;
        do_reset();
        req_frame = {frm[3], frm[2], frm[1], frm[0]};
        req_valid = 4'b1010;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
`ifdef ARB_FIXED_PRIO_EN
            exp = 1;
`else
            exp = (k % 2 == 0) ? 1 : 3;
`endif
            @(negedge clk); #1;
            n_vec++; if (out_src !== 2'(exp) || out_frame !== frm[exp]) begin n_bad++; $display("FAIL two_req_src[%0d] got=%0d exp=%0d", k, out_src, exp); end
            @(negedge clk);
        end
        req_valid = 4'b0000;
    endtask

    task automatic test_saturation();
        do_reset();
        #1;
        n_vec++; if (s_frame_count !== 16'hFFFD) begin n_bad++; $display("FAIL sat_preload got=%h exp=fffd", s_frame_count); end
        repeat (2) @(negedge clk);
        #1;
        n_vec++; if (s_frame_count !== 16'hFFFE) begin n_bad++; $display("FAIL sat_step got=%h exp=fffe", s_frame_count); end
        repeat (2) @(negedge clk);
        #1;
        n_vec++; if (s_frame_count !== 16'hFFFF) begin n_bad++; $display("FAIL sat_top got=%h exp=ffff", s_frame_count); end
        repeat (10) @(negedge clk);
        #1;
        n_vec++; if (s_frame_count !== 16'hFFFF) begin n_bad++; $display("FAIL sat_hold got=%h exp=ffff", s_frame_count); end
    endtask

    initial begin
        n_vec       = 0;
        n_bad       = 0;
        s_req_frame = {NR{21'h0_5A5_3C}};
        s_req_valid = 4'b0001;
        s_out_ready = 1'b1;
        for (int i = 0; i < NR; i++) begin
            frm[i] = pack_frame(i[0], 12'(12'h100 + i), 8'(8'hA0 + i));
        end
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_idle_ready();
        test_reset_mid_offer();
        test_two_req();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_frame_arbiter.md
UART_TX_FRAME_ARBITER -- requirements
Module: uart_tx_frame_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of frame requesters (2..8).
REQ-002 Parameter FRAME_W, default 21: frame width, packed as {mode, addr[11:0], data[7:0]}.
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req_frame  input  NUM_REQ*FRAME_W  requester frames; requester i occupies bits [i*FRAME_W +: FRAME_W].
REQ-006 req_valid  input  NUM_REQ  per-requester frame-available flags.
REQ-007 req_ready  output  NUM_REQ  per-requester one-cycle accept strobe.
REQ-008 out_frame  output  FRAME_W  frame offered to the UART TX adapter.
REQ-009 out_valid  output  1  out_frame is valid.
REQ-010 out_ready  input  1  TX adapter can accept a frame.
REQ-011 out_src  output  $clog2(NUM_REQ)  index of the requester that owns out_frame.
REQ-012 frame_count  output  16  saturating count of frames delivered downstream.

Function
REQ-013 FSM states are IDLE and OFFER; the encoding comes from the package.
REQ-014 In IDLE with any req_valid set, the block selects grant g, captures req_frame[g] into out_frame, sets out_src=g, pulses req_ready[g] high for exactly that cycle, and enters OFFER.
REQ-015 In IDLE, the block asserts req_ready only in a cycle where the matching req_valid is high, and asserts at most one req_ready bit per cycle.
REQ-016 Latency: a frame accepted at edge N appears with out_valid=1 after edge N (visible in cycle N+1).
REQ-017 In OFFER, out_valid=1, out_frame and out_src stay stable, and req_ready stays all-zero.
REQ-018 OFFER->IDLE occurs on the edge where out_valid && out_ready; at that edge out_valid drops to 0, last_grant<=out_src, and frame_count increments, saturating at 16'hFFFF.
REQ-019 An accept in IDLE may occur in the cycle immediately after a downstream handshake; minimum spacing is 2 cycles per frame.
REQ-020 Round-robin selection: g is the first requester with req_valid set, searching from last_grant+1 upward with wrap modulo NUM_REQ; last_grant resets to NUM_REQ-1, so requester 0 wins the first tie.
REQ-021 With a single requester active, that requester is served on every IDLE visit.
REQ-022 Requesters hold req_valid and req_frame stable until they see req_ready; the block samples req_frame only in the grant cycle.
REQ-023 out_ready high while in IDLE has no effect.

Reset
REQ-024 On rst: state=IDLE, out_valid=0, out_frame=0, out_src=0, req_ready=0, frame_count=0, last_grant=NUM_REQ-1.
REQ-025 Reset during OFFER discards the held frame and does not count it; that frame is not re-offered.

Configuration
REQ-026 With ARB_FIXED_PRIO_EN defined, g is the lowest-indexed valid requester and last_grant is ignored.
REQ-027 With ARB_FIXED_PRIO_EN undefined, round-robin selection per REQ-020 applies.
REQ-028 The macro changes only the selection logic; ports and timing are identical in both builds.

Structure
REQ-029 Shared package uart_arb_pkg holds FRAME_W default, the field slice positions (mode/addr/data), and the IDLE/OFFER state encoding.
REQ-030 Combinational sub-module uart_arb_rr_pick (inputs: valid vector and last_grant; outputs: grant index and any_valid) contains both selection variants under the macro.

Verification
REQ-031 Single request: req_valid=4'b0001, req_frame[0]=21'h1_ABC_5A, out_ready=1 -> req_ready=4'b0001 for one cycle, then out_valid=1 with out_frame=21'h1ABC5A and out_src=0; frame_count becomes 1.
REQ-032 Round-robin fairness: all four requesters valid continuously, out_ready=1 -> out_src sequence 0,1,2,3,0,1; each grant is spaced 2 cycles apart.
REQ-033 Backpressure: out_ready=0 for 50 cycles during OFFER -> out_frame and out_src stable and req_ready=0 throughout; handshake completes one edge after out_ready rises.
REQ-034 Reset mid-OFFER: assert rst while out_valid=1 -> out_valid=0 immediately (asynchronously) and frame_count unchanged.
REQ-035 ARB_FIXED_PRIO_EN build, requesters 1 and 3 valid continuously -> out_src always 1; requester 3 is never granted.
REQ-036 Saturation: preload or run 65536 frames -> frame_count holds 16'hFFFF and does not wrap.
